// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the instruction-fetch state encoding.
package cpu_pkg;
  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  typedef enum logic {FETCH, FLUSH} fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instruction} entries; flush empties it in one cycle.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;

  assign rdata = mem[rp];
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wp] <= wdata;
  end

  // Flush outranks push and pop so a redirect never lets a stale word survive.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: credit-limited in-order reads, redirect flush with drop counting,
// and a small buffer presenting {instruction, pc} to the core.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = XLEN,
  parameter int                DATA_W   = INSTR_W,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] instr_pc
);
  localparam int                CW   = $clog2(DEPTH) + 1;
  localparam int                FW   = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  fetch_state_e      state;
  logic [ADDR_W-1:0] fetch_pc, held_addr, rsp_pc, target;
  logic              held_vld, held_n, new_ok, accept, live_rsp, pop, empty;
  logic [CW-1:0]     outstanding, drop_cnt, count;
  logic [CW:0]       credit_sum, inflight_n;
  logic [FW-1:0]     head;

  assign target   = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign live_rsp = mem_rsp_valid && (drop_cnt == '0);
  assign pop      = instr_valid && instr_ready && !redirect;

  // A same-cycle pop frees its slot, which keeps one fetch per cycle at DEPTH=2.
  assign credit_sum = {1'b0, count} + {1'b0, outstanding} - {{CW{1'b0}}, pop};
  assign new_ok     = !rst && (state == FETCH) && !held_vld && !redirect &&
                      (credit_sum < (CW+1)'(DEPTH));

  assign mem_req_valid = !rst && (held_vld || new_ok);
  assign mem_req_addr  = held_vld ? held_addr : fetch_pc;
  assign accept        = mem_req_valid && mem_req_ready;
  assign held_n        = mem_req_valid && !mem_req_ready;

  // Reads still owed by memory after this cycle, live or to-be-dropped.
  assign inflight_n = {1'b0, outstanding} + {1'b0, drop_cnt} +
                      {{CW{1'b0}}, accept} - {{CW{1'b0}}, mem_rsp_valid};

  fetch_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (live_rsp),
    .wdata ({rsp_pc, mem_rsp_data}),
    .pop   (pop),
    .flush (redirect),
    .rdata (head),
    .count (count),
    .empty (empty)
  );

  assign instr_valid = !empty;
  assign instruction = instr_valid ? head[DATA_W-1:0]  : '0;
  assign instr_pc    = instr_valid ? head[FW-1:DATA_W] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      held_vld    <= 1'b0;
      held_addr   <= '0;
      rsp_pc      <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      held_vld <= held_n;
      if (held_n) held_addr <= mem_req_addr;

      // rsp_pc tracks the pc of the oldest live read; live reads are always consecutive.
      if (accept && outstanding == CW'(live_rsp)) rsp_pc <= mem_req_addr;
      else if (live_rsp)                           rsp_pc <= rsp_pc + STEP;

      case (state)
        FETCH: begin
          if (redirect) begin
            fetch_pc    <= target;
            outstanding <= '0;
            drop_cnt    <= inflight_n[CW-1:0];
            if (inflight_n != '0 || held_n) state <= FLUSH;
          end else begin
            if (accept) fetch_pc <= fetch_pc + STEP;
            outstanding <= outstanding + CW'(accept) - CW'(live_rsp);
          end
        end
        FLUSH: begin
          if (redirect) fetch_pc <= target;
          drop_cnt <= inflight_n[CW-1:0];
          if (inflight_n == '0 && !held_n) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end
endmodule
